// File: rtl/conv2d_engine.sv
// -----------------------------------------------------------------------------
// conv2d_engine
//
// Parametrised 2-D valid-mode convolution engine. A CONV_DIM x CONV_DIM kernel
// and a MATRIX_DIM x MATRIX_DIM matrix are loaded row-major over one shared
// valid/ready input stream. On start, every output position is computed with a
// single signed MAC (one product per cycle). Each result is then presented
// under valid/ready backpressure, in row-major order.
//
// Optional build macro: CONV_RELU_EN
//   defined   -> presented value is ReLU of the accumulator
//   undefined -> raw signed accumulator is presented
//
// Ports:
//   clk          clock, all logic on the rising edge
//   rst          synchronous active-high reset
//   load_kernel  strobe, start a kernel load (IDLE only)
//   load_matrix  strobe, start a matrix load (IDLE only)
//   start        strobe, start a convolution run (IDLE only)
//   in_valid     data_in holds a valid element
//   in_ready     engine accepts data_in this cycle
//   data_in      signed element, row-major order
//   busy         FSM is not IDLE
//   out_valid    out_data holds a result
//   out_ready    consumer accepts out_data
//   out_data     signed convolution result
//   out_last     qualifies the final result of a run
//   done         one-cycle pulse after the final result is accepted
// -----------------------------------------------------------------------------
module conv2d_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int MATRIX_DIM = 16,
  parameter int CONV_DIM   = 3,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(CONV_DIM*CONV_DIM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_kernel,
  input  logic                  load_matrix,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_last,
  output logic                  done
);

  localparam int K_N     = CONV_DIM * CONV_DIM;
  localparam int M_N     = MATRIX_DIM * MATRIX_DIM;
  localparam int OUT_DIM = MATRIX_DIM - CONV_DIM + 1;
  localparam int K_AW    = (K_N > 1)     ? $clog2(K_N)     : 1;
  localparam int M_AW    = (M_N > 1)     ? $clog2(M_N)     : 1;
  localparam int C_W     = (CONV_DIM > 1) ? $clog2(CONV_DIM) : 1;
  localparam int O_W     = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int EXT_W   = (ACC_WIDTH > 2*DATA_WIDTH) ? ACC_WIDTH : 2*DATA_WIDTH;

  localparam logic [M_AW-1:0] K_LOAD_LAST = M_AW'(K_N - 1);
  localparam logic [M_AW-1:0] M_LOAD_LAST = M_AW'(M_N - 1);
  localparam logic [K_AW-1:0] K_IDX_LAST  = K_AW'(K_N - 1);
  localparam logic [C_W-1:0]  KX_LAST     = C_W'(CONV_DIM - 1);
  localparam logic [O_W-1:0]  O_LAST      = O_W'(OUT_DIM - 1);
  // Address step from the end of one window row to the start of the next.
  localparam logic [M_AW-1:0] WIN_ROW_STEP = M_AW'(MATRIX_DIM - CONV_DIM + 1);
  // Base step when the output column wraps: (i+1)*MD - (i*MD + OUT_DIM-1).
  localparam logic [M_AW-1:0] OUT_ROW_STEP = M_AW'(CONV_DIM);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_K  = 3'd1;
  localparam logic [2:0] ST_LOAD_M  = 3'd2;
  localparam logic [2:0] ST_MAC     = 3'd3;
  localparam logic [2:0] ST_PRESENT = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]            r_state;
  logic [M_AW-1:0]       r_load_idx;
  logic [K_AW-1:0]       r_kidx;     // linear kernel index, kx fastest
  logic [C_W-1:0]        r_kx;       // kernel column, detects window-row wrap
  logic [O_W-1:0]        r_oi;
  logic [O_W-1:0]        r_oj;
  logic [M_AW-1:0]       r_base;     // matrix address of window origin (i, j)
  logic [M_AW-1:0]       r_maddr;    // matrix address of current tap
  logic [ACC_WIDTH-1:0]  r_acc;

  logic signed [DATA_WIDTH-1:0] r_kernel [K_N];
  logic signed [DATA_WIDTH-1:0] r_matrix [M_N];

  logic                         w_load_fire;
  logic                         w_last_pos;
  logic [M_AW-1:0]              w_next_base;
  logic signed [DATA_WIDTH-1:0] w_k;
  logic signed [DATA_WIDTH-1:0] w_m;
  logic signed [2*DATA_WIDTH-1:0] w_prod;
  logic signed [EXT_W-1:0]      w_prod_wide;
  logic [ACC_WIDTH-1:0]         w_prod_acc;
  logic [ACC_WIDTH-1:0]         w_present_val;

  assign in_ready    = (r_state == ST_LOAD_K) || (r_state == ST_LOAD_M);
  assign w_load_fire = in_valid && in_ready;
  assign w_last_pos  = (r_oi == O_LAST) && (r_oj == O_LAST);
  assign w_next_base = (r_oj == O_LAST) ? r_base + OUT_ROW_STEP
                                        : r_base + M_AW'(1);

  assign w_k         = r_kernel[r_kidx];
  assign w_m         = r_matrix[r_maddr];
  assign w_prod      = w_k * w_m;
  // Signed size cast sign-extends; slicing then wraps for narrow ACC_WIDTH.
  assign w_prod_wide = EXT_W'(w_prod);
  assign w_prod_acc  = w_prod_wide[ACC_WIDTH-1:0];

`ifdef CONV_RELU_EN
  assign w_present_val = r_acc[ACC_WIDTH-1] ? '0 : r_acc;
`else
  assign w_present_val = r_acc;
`endif

  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_PRESENT);
  assign out_last  = out_valid && w_last_pos;
  // Gated so the partial sum never leaks while the MAC is running.
  assign out_data  = out_valid ? w_present_val : '0;
  assign done      = (r_state == ST_DONE);

  // NOTE: element storage has no reset so it survives rst and maps to plain
  // RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (!rst && w_load_fire) begin
      if (r_state == ST_LOAD_K) r_kernel[r_load_idx[K_AW-1:0]] <= data_in;
      else                      r_matrix[r_load_idx]            <= data_in;
    end
  end

  // NOTE: every register below is assigned with <= so all state updates
  // see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_load_idx <= '0;
      r_kidx     <= '0;
      r_kx       <= '0;
      r_oi       <= '0;
      r_oj       <= '0;
      r_base     <= '0;
      r_maddr    <= '0;
      r_acc      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Priority: load_kernel > load_matrix > start; losers are dropped.
          if (load_kernel) begin
            r_state    <= ST_LOAD_K;
            r_load_idx <= '0;
          end else if (load_matrix) begin
            r_state    <= ST_LOAD_M;
            r_load_idx <= '0;
          end else if (start) begin
            r_state <= ST_MAC;
            r_acc   <= '0;
            r_kidx  <= '0;
            r_kx    <= '0;
            r_oi    <= '0;
            r_oj    <= '0;
            r_base  <= '0;
            r_maddr <= '0;
          end
        end

        ST_LOAD_K, ST_LOAD_M: begin
          if (w_load_fire) begin
            if (r_load_idx == ((r_state == ST_LOAD_K) ? K_LOAD_LAST : M_LOAD_LAST)) begin
              r_state    <= ST_IDLE;
              r_load_idx <= '0;
            end else begin
              r_load_idx <= r_load_idx + M_AW'(1);
            end
          end
        end

        ST_MAC: begin
          r_acc <= r_acc + w_prod_acc;
          if (r_kidx == K_IDX_LAST) begin
            r_state <= ST_PRESENT;
          end else begin
            r_kidx <= r_kidx + K_AW'(1);
            if (r_kx == KX_LAST) begin
              r_kx    <= '0;
              r_maddr <= r_maddr + WIN_ROW_STEP;
            end else begin
              r_kx    <= r_kx + C_W'(1);
              r_maddr <= r_maddr + M_AW'(1);
            end
          end
        end

        ST_PRESENT: begin
          if (out_ready) begin
            if (w_last_pos) begin
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_MAC;
              r_acc   <= '0;
              r_kidx  <= '0;
              r_kx    <= '0;
              r_base  <= w_next_base;
              r_maddr <= w_next_base;
              if (r_oj == O_LAST) begin
                r_oj <= '0;
                r_oi <= r_oi + O_W'(1);
              end else begin
                r_oj <= r_oj + O_W'(1);
              end
            end
          end
        end

        ST_DONE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_engine.sv
// -----------------------------------------------------------------------------
// tb_conv2d_engine
//
// Self-checking bench for conv2d_engine at default parameters. Expected
// results come from a direct nested-loop convolution over the loaded arrays,
// plus hand-derived constants for the first/last result of each table entry.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_conv2d_engine;

  localparam int DW     = 8;
  localparam int MD     = 16;
  localparam int CD     = 3;
  localparam int AW     = 2*DW + $clog2(CD*CD);
  localparam int OD     = MD - CD + 1;
  localparam int NOUT   = OD * OD;
  localparam int NMAC   = CD * CD;
  localparam int BUDGET = NOUT * (NMAC + 1) * 4 + 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_kernel, load_matrix, start;
  logic          in_valid, in_ready;
  logic [DW-1:0] data_in;
  logic          busy, out_valid, out_ready, out_last, done;
  logic [AW-1:0] out_data;

  int     n_checks = 0;
  int     n_fail   = 0;
  int     kmem [CD][CD];
  int     mmem [MD][MD];
  longint exp_q [NOUT];

  typedef struct {
    string  name;
    int     kmode;
    int     mmode;
    int     rmode;      // 0: out_ready tied high, 1: random backpressure
    longint exp_first;  // raw signed out[0][0]
    longint exp_last;   // raw signed out[OD-1][OD-1]
  } vec_t;

  conv2d_engine #(.DATA_WIDTH(DW), .MATRIX_DIM(MD), .CONV_DIM(CD)) dut (
    .clk(clk), .rst(rst),
    .load_kernel(load_kernel), .load_matrix(load_matrix), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wrap to the output width, then apply the optional ReLU.
  function automatic longint to_out(longint raw);
    longint v;
    v = raw & ((longint'(1) << AW) - 1);
`ifdef CONV_RELU_EN
    if (v[AW-1]) v = 0;
`endif
    return v;
  endfunction

  function automatic void build_model();
    longint s;
    for (int i = 0; i < OD; i++)
      for (int j = 0; j < OD; j++) begin
        s = 0;
        for (int ky = 0; ky < CD; ky++)
          for (int kx = 0; kx < CD; kx++)
            s += longint'(kmem[ky][kx]) * longint'(mmem[i+ky][j+kx]);
        exp_q[i*OD + j] = to_out(s);
      end
  endfunction

  function automatic int kval(int mode, int r, int c);
    case (mode)
      0:       return (r == CD/2 && c == CD/2) ? 1 : 0;
      1:       return 1;
      2:       return -1;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  function automatic int mval(int mode, int r, int c);
    case (mode)
      0:       return r + c;
      1:       return 1;
      2:       return 127;
      3:       return r;
      default: return int'($urandom_range(0, 255)) - 128;
    endcase
  endfunction

  task automatic fill(input int km, input int mm);
    for (int r = 0; r < CD; r++) for (int c = 0; c < CD; c++) kmem[r][c] = kval(km, r, c);
    for (int r = 0; r < MD; r++) for (int c = 0; c < MD; c++) mmem[r][c] = mval(mm, r, c);
  endtask

  // Entered and left on a falling edge with all strobes low.
  task automatic load_mem(input bit is_k);
    int  n, idx, guard, v;
    bit  fire;
    n = is_k ? NMAC : MD*MD;
    if (is_k) load_kernel = 1'b1; else load_matrix = 1'b1;
    @(negedge clk);
    load_kernel = 1'b0;
    load_matrix = 1'b0;
    check(is_k ? "load_k_busy" : "load_m_busy", busy, 1);
    idx = 0;
    guard = 0;
    while (idx < n && guard < n*4 + 20) begin
      v        = is_k ? kmem[idx/CD][idx%CD] : mmem[idx/MD][idx%MD];
      in_valid = ($urandom_range(0, 3) != 0);
      data_in  = v[DW-1:0];
      fire     = in_valid && in_ready;
      @(negedge clk);
      guard++;
      if (fire) idx++;
    end
    in_valid = 1'b0;
    check(is_k ? "load_k_beats" : "load_m_beats", idx, n);
    check(is_k ? "load_k_idle" : "load_m_idle", busy, 0);
  endtask

  // Full run compared against exp_q. stall0 holds out_ready low on result 0.
  task automatic run_conv(input int rmode, input int stall0, input bit chk_int,
                          output longint first_v, output longint last_v);
    int n, cyc, last_rise, stalls;
    bit prev_valid, rdy;
    n = 0; cyc = 0; stalls = 0; prev_valid = 0; last_rise = 0;
    first_v = -1; last_v = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (n < NOUT && cyc < BUDGET) begin
      check("run_in_ready", in_ready, 0);
      if (out_valid) begin
        if (!prev_valid) begin
          if (n == 0)       check("first_latency", cyc, NMAC + 1);
          else if (chk_int) check("result_interval", cyc - last_rise, NMAC + 1);
          last_rise = cyc;
        end
        check("result_data", out_data, exp_q[n]);
        check("result_last", out_last, (n == NOUT-1));
        if (n == 0) first_v = longint'(out_data);
        if (n == NOUT-1) last_v = longint'(out_data);
        if (n == 0 && stalls < stall0) begin
          rdy = 1'b0;
          stalls++;
        end else begin
          rdy = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        out_ready = rdy;
        if (rdy) n++;
      end else begin
        check("idle_last_low", out_last, 0);
        out_ready = (rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      prev_valid = out_valid;
      @(negedge clk);
      cyc++;
    end
    check("run_result_count", n, NOUT);
    out_ready = 1'b0;
    check("done_pulse", done, 1);
    check("done_no_valid", out_valid, 0);
    @(negedge clk);
    check("done_cleared", done, 0);
    check("done_back_idle", busy, 0);
  endtask

  initial begin
    vec_t   vecs [4];
    longint f, l;
    int     guard, n;

    vecs[0] = '{"identity", 0, 0, 0, 2,     28};
    vecs[1] = '{"ones",     1, 1, 0, 9,     9};
    vecs[2] = '{"neg_k",    2, 2, 0, -1143, -1143};
    vecs[3] = '{"row_sum",  1, 3, 1, 9,     126};

    rst = 1'b1; load_kernel = 0; load_matrix = 0; start = 0;
    in_valid = 0; data_in = '0; out_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven runs.
    for (int v = 0; v < 4; v++) begin
      fill(vecs[v].kmode, vecs[v].mmode);
      load_mem(1'b1);
      load_mem(1'b0);
      build_model();
      run_conv(vecs[v].rmode, 0, (vecs[v].rmode == 0), f, l);
      check({vecs[v].name, "_first"}, f, to_out(vecs[v].exp_first));
      check({vecs[v].name, "_last"},  l, to_out(vecs[v].exp_last));
    end

    // Backpressure on result 0, identity kernel over m = r+c.
    fill(0, 0);
    load_mem(1'b1);
    load_mem(1'b0);
    build_model();
    run_conv(0, 5, 1'b0, f, l);
    check("stall_first", f, 2);

    // Simultaneous strobes: kernel load wins, start during LOAD_K ignored.
    load_kernel = 1; load_matrix = 1; start = 1;
    @(negedge clk);
    load_kernel = 0; load_matrix = 0; start = 0;
    check("prio_busy", busy, 1);
    check("prio_in_ready", in_ready, 1);
    start = 1;
    @(negedge clk);
    start = 0;
    check("loadk_start_busy", busy, 1);
    check("loadk_start_no_valid", out_valid, 0);
    for (int idx = 0; idx < NMAC; idx++) begin
      check("prio_beat_ready", in_ready, 1);
      in_valid = 1'b1;
      data_in  = DW'(kmem[idx/CD][idx%CD]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("prio_kernel_len", busy, 0);
    @(negedge clk);
    check("prio_dropped_busy", busy, 0);
    check("prio_dropped_valid", out_valid, 0);

    // Reset during MAC of result 20, then a clean rerun on retained storage.
    start = 1;
    @(negedge clk);
    start = 0;
    n = 0; guard = 0;
    out_ready = 1'b1;
    while (n < 20 && guard < BUDGET) begin
      if (out_valid) begin
        check("pre_rst_data", out_data, exp_q[n]);
        n++;
      end
      @(negedge clk);
      guard++;
    end
    check("pre_rst_count", n, 20);
    repeat (3) @(negedge clk);
    check("pre_rst_in_mac", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_in_ready", in_ready, 0);
    run_conv(0, 0, 1'b1, f, l);
    check("rerun_first", f, 2);
    check("rerun_last", l, 28);

    // Randomized data with random bubbles and backpressure.
    for (int t = 0; t < 2; t++) begin
      fill(3, 4);
      load_mem(1'b1);
      load_mem(1'b0);
      build_model();
      run_conv(1, 0, 1'b0, f, l);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv2d_engine.md
Name: conv2d_engine

Overview:
Parametrised 2-D valid-mode convolution engine; successor to the fixed 8-bit/16x16/3x3 TPU datapath.
- Loads a CONV_DIM x CONV_DIM kernel and a MATRIX_DIM x MATRIX_DIM matrix over a shared streaming input with valid/ready.
- On start, computes every output with a single signed MAC, one product per cycle.
- Streams the results out row-major under valid/ready backpressure, with last/done signalling.

Parameters:
DATA_WIDTH, 8, width of kernel and matrix elements (signed two's complement)
MATRIX_DIM, 16, input matrix side length (>= CONV_DIM)
CONV_DIM, 3, kernel side length (>= 1)
ACC_WIDTH, 2*DATA_WIDTH+$clog2(CONV_DIM*CONV_DIM), accumulator and output width

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
load_kernel  input  1  strobe: begin kernel load (honoured in IDLE only)
load_matrix  input  1  strobe: begin matrix load (honoured in IDLE only)
start  input  1  strobe: begin convolution (honoured in IDLE only)
in_valid  input  1  data_in holds a valid element
in_ready  output  1  engine accepts data_in this cycle
data_in  input  DATA_WIDTH  element, row-major order
busy  output  1  high whenever FSM is not IDLE
out_valid  output  1  out_data valid
out_ready  input  1  consumer accepts out_data
out_data  output  ACC_WIDTH  signed convolution result
out_last  output  1  qualifies the final result of a run
done  output  1  one-cycle pulse after final result accepted

Behaviour:
- Reset values: FSM=IDLE, all counters and accumulator 0, in_ready=0, busy=0, out_valid=0, out_data=0, out_last=0, done=0.
- Reset does not clear kernel or matrix storage; contents are retained.
- OUT_DIM = MATRIX_DIM-CONV_DIM+1. out[i][j] = sum over (ky,kx) of k[ky][kx]*m[i+ky][j+kx].
- FSM states: IDLE, LOAD_K, LOAD_M, MAC, PRESENT, DONE.
- IDLE strobe priority: load_kernel > load_matrix > start; lower-priority strobes in the same cycle are dropped. Strobes in any other state are ignored.
- LOAD_K: in_ready=1. Each in_valid&&in_ready beat writes the next kernel element, row-major.
  - After CONV_DIM^2 beats, return to IDLE; no done pulse.
- LOAD_M: same rules, MATRIX_DIM^2 beats.
- No data is accepted outside the load states; in_ready=0 there.
- MAC:
  - Accumulator cleared on entry to each output position.
  - One signed DATA_WIDTH x DATA_WIDTH product per cycle, sign-extended to ACC_WIDTH and accumulated modulo 2^ACC_WIDTH.
  - Kernel index walks kx fastest, then ky. After CONV_DIM^2 cycles, go to PRESENT.
- PRESENT:
  - out_valid=1; out_data and out_last held stable until out_ready.
  - On acceptance: advance the output position (j fastest, then i) and return to MAC, or go to DONE after position (OUT_DIM-1, OUT_DIM-1).
- Per-output latency: CONV_DIM^2 MAC cycles + 1 cycle to PRESENT. With out_ready tied high, one result every CONV_DIM^2+1 cycles.
- out_last=1 only during PRESENT of the final position.
- DONE: done=1 for exactly one cycle, then IDLE.
- Rerunning start without reloading reuses the stored kernel and matrix.
- rst asserted in any state (mid-load, mid-MAC, mid-PRESENT): next cycle is IDLE with reset output values. A partial load leaves the written elements modified.
- Default ACC_WIDTH cannot overflow. A narrower override wraps silently.

Optional Feature:
Macro: CONV_RELU_EN
- Defined: out_data is ReLU of the accumulator; negative results present as 0, non-negative unchanged. Clamp is combinational on the presented value; latency unchanged.
- Undefined: raw signed accumulator presented.

Test Plan:
1. Identity kernel (centre 1, others 0), m[r][c]=r+c, default params, out_ready=1 -> 196 results, out[i][j]=i+j+2, out_last on 196th only, done one cycle later.
2. Kernel all 1, matrix all 1 -> every result 9. Interval between out_valid rising edges is exactly 10 cycles.
3. Kernel all 0xFF (-1), matrix all 0x7F -> out_data=0xFFB89 (-1143). With CONV_RELU_EN -> 0.
4. Backpressure: hold out_ready low 5 cycles on result 0 -> out_valid and out_data stable throughout. Sequence unchanged after release; in_ready stays 0.
5. Assert load_kernel, load_matrix and start in the same IDLE cycle -> LOAD_K entered; the other strobes dropped; start during LOAD_K ignored (busy stays tied to LOAD_K).
6. Pulse rst during MAC of result 20 -> IDLE next cycle, all outputs 0. Re-issue start -> full 196-result run matching scenario 1.
